// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the 7:1 LVDS receive word aligner: lane width,
// default clock-lane pattern, FSM state encoding and slip-position wrap helper.
package lvds_rx_pkg;

   localparam int         LANE_W      = 7;
   localparam logic [6:0] CLK_PAT_DEF = 7'b1100011;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_SETTLE    = 3'd1,
      ST_CHECK     = 3'd2,
      ST_SLIP      = 3'd3,
      ST_SLIP_WAIT = 3'd4,
      ST_LOCKED    = 3'd5
   } state_t;

   // Slip position walks 0..6, one step per bitslip, then wraps.
   function automatic logic [2:0] slip_next(input logic [2:0] cur);
      logic [2:0] nxt;
      if (cur == 3'd6) begin
         nxt = 3'd0;
      end else begin
         nxt = cur + 3'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/lvds_rx_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into the
// pixel-clock domain.
module lvds_rx_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture; q is safe to use in the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/lvds_7to1_rx_aligner.sv
// Word-alignment controller for the 7:1 LVDS receive path: slips the
// deserializers until the clock lane shows the transmit pattern, then forwards data.
module lvds_7to1_rx_aligner
   import lvds_rx_pkg::*;
#(
   parameter int         LANES      = 4,
   parameter logic [6:0] CLK_PAT    = CLK_PAT_DEF,
   parameter int         SETTLE_CYC = 64,
   parameter int         SLIP_WAIT  = 8,
   parameter int         MATCH_CNT  = 16,
   parameter int         LOSS_CNT   = 4
) (
   input  logic                      clkin,
   input  logic                      reset_n,
   input  logic                      pll_lock,
   input  logic [LANE_W-1:0]         clk_word,
   input  logic [LANE_W*LANES-1:0]   data_word,
   output logic                      bitslip,
   output logic                      aligned,
   output logic [LANE_W*LANES-1:0]   data_out,
   output logic                      data_valid,
   output logic [2:0]                slip_cnt,
   output logic                      align_fail
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int WW = $clog2(SLIP_WAIT + 1);
   localparam int MW = $clog2(MATCH_CNT + 1);
   localparam int LW = $clog2(LOSS_CNT + 1);

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [WW-1:0] WAIT_LAST   = WW'(SLIP_WAIT - 1);
   localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_CNT - 1);
   localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_CNT - 1);

   state_t        state, state_nxt;
   logic [SW-1:0] settle_ctr, settle_nxt;
   logic [WW-1:0] wait_ctr, wait_nxt;
   logic [MW-1:0] match_ctr, match_nxt;
   logic [LW-1:0] loss_ctr, loss_nxt;
   logic [2:0]    slip_nxt;
   logic          fail_nxt;
   logic          lock_sync;
   logic          pat_match;

   lvds_rx_sync2 u_lock_sync (
      .clk   (clkin),
      .rst_n (reset_n),
      .d     (pll_lock),
      .q     (lock_sync)
   );

   assign pat_match = (clk_word == CLK_PAT);

   // State register plus all FSM counters and the sticky/slip bookkeeping.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_WAIT_LOCK;
         settle_ctr <= {SW{1'b0}};
         wait_ctr   <= {WW{1'b0}};
         match_ctr  <= {MW{1'b0}};
         loss_ctr   <= {LW{1'b0}};
         slip_cnt   <= 3'd0;
         align_fail <= 1'b0;
      end else begin
         state      <= state_nxt;
         settle_ctr <= settle_nxt;
         wait_ctr   <= wait_nxt;
         match_ctr  <= match_nxt;
         loss_ctr   <= loss_nxt;
         slip_cnt   <= slip_nxt;
         align_fail <= fail_nxt;
      end
   end

   // Next-state and counter update; loss of PLL lock overrides everything.
   always_comb begin
      state_nxt  = state;
      settle_nxt = settle_ctr;
      wait_nxt   = wait_ctr;
      match_nxt  = match_ctr;
      loss_nxt   = loss_ctr;
      slip_nxt   = slip_cnt;
      fail_nxt   = align_fail;
      if (!lock_sync && (state != ST_WAIT_LOCK)) begin
         // slip_cnt and align_fail survive a lock drop; the rest restarts.
         state_nxt  = ST_WAIT_LOCK;
         settle_nxt = {SW{1'b0}};
         wait_nxt   = {WW{1'b0}};
         match_nxt  = {MW{1'b0}};
         loss_nxt   = {LW{1'b0}};
      end else begin
         case (state)
            ST_WAIT_LOCK: begin
               if (lock_sync) begin
                  state_nxt  = ST_SETTLE;
                  settle_nxt = {SW{1'b0}};
               end else begin
                  state_nxt  = ST_WAIT_LOCK;
               end
            end
            ST_SETTLE: begin
               if (settle_ctr == SETTLE_LAST) begin
                  state_nxt  = ST_CHECK;
                  settle_nxt = {SW{1'b0}};
                  match_nxt  = {MW{1'b0}};
               end else begin
                  settle_nxt = settle_ctr + {{(SW-1){1'b0}}, 1'b1};
               end
            end
            ST_CHECK: begin
               if (!pat_match) begin
                  state_nxt = ST_SLIP;
                  match_nxt = {MW{1'b0}};
               end else if (match_ctr == MATCH_LAST) begin
                  state_nxt = ST_LOCKED;
                  match_nxt = {MW{1'b0}};
                  loss_nxt  = {LW{1'b0}};
               end else begin
                  match_nxt = match_ctr + {{(MW-1){1'b0}}, 1'b1};
               end
            end
            ST_SLIP: begin
               slip_nxt  = slip_next(slip_cnt);
               fail_nxt  = align_fail | (slip_cnt == 3'd6);
               state_nxt = ST_SLIP_WAIT;
               wait_nxt  = {WW{1'b0}};
            end
            ST_SLIP_WAIT: begin
               if (wait_ctr == WAIT_LAST) begin
                  state_nxt = ST_CHECK;
                  wait_nxt  = {WW{1'b0}};
                  match_nxt = {MW{1'b0}};
               end else begin
                  wait_nxt  = wait_ctr + {{(WW-1){1'b0}}, 1'b1};
               end
            end
            ST_LOCKED: begin
               if (pat_match) begin
                  loss_nxt = {LW{1'b0}};
               end else if (loss_ctr == LOSS_LAST) begin
                  state_nxt = ST_CHECK;
                  loss_nxt  = {LW{1'b0}};
                  match_nxt = {MW{1'b0}};
               end else begin
                  loss_nxt = loss_ctr + {{(LW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_nxt = ST_WAIT_LOCK;
            end
         endcase
      end
   end

   // Registered control outputs; aligned and bitslip track the state being entered.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         bitslip    <= 1'b0;
         aligned    <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         bitslip    <= (state_nxt == ST_SLIP);
         aligned    <= (state_nxt == ST_LOCKED);
         data_valid <= (state == ST_LOCKED);
      end
   end

   // Data register, one cycle of latency.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= {(LANE_W*LANES){1'b0}};
      end else begin
         data_out <= data_word;
      end
   end

endmodule

// File: tb/tb_lvds_7to1_rx_aligner.sv
// Directed bench for lvds_7to1_rx_aligner; models the deserializer bitslip as
// a rotate-left of the clock-lane word.
module tb_lvds_7to1_rx_aligner;

   localparam logic [6:0] PAT = 7'b1100011;

   logic        clkin = 1'b0;
   logic        reset_n = 1'b0;
   logic        pll_lock = 1'b0;
   logic [6:0]  clk_word = 7'h00;
   logic [27:0] data_word = 28'h0;
   logic        bitslip, aligned, data_valid, align_fail;
   logic [27:0] data_out;
   logic [2:0]  slip_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int slips_seen = 0;
   int last_pulse = -1;
   int min_gap = 1000;
   int base_rot = 0;
   bit never_match = 1'b0;
   bit inject = 1'b0;
   int n;
   int slips_before;

   lvds_7to1_rx_aligner dut (
      .clkin      (clkin),
      .reset_n    (reset_n),
      .pll_lock   (pll_lock),
      .clk_word   (clk_word),
      .data_word  (data_word),
      .bitslip    (bitslip),
      .aligned    (aligned),
      .data_out   (data_out),
      .data_valid (data_valid),
      .slip_cnt   (slip_cnt),
      .align_fail (align_fail)
   );

   always #5 clkin = ~clkin;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] rotl7(input logic [6:0] w, input int k);
      logic [6:0] r;
      r = w;
      for (int i = 0; i < k; i++) r = {r[5:0], r[6]};
      return r;
   endfunction

   // Drive the modelled clock-lane word, advance one clock, record slips.
   task automatic step();
      if (inject || never_match) clk_word = 7'h00;
      else clk_word = rotl7(PAT, (base_rot + slips_seen) % 7);
      @(posedge clkin);
      #1;
      cyc++;
      if (bitslip) begin
         if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
         last_pulse = cyc;
         slips_seen++;
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      slips_seen = 0;
      last_pulse = -1;
      min_gap = 1000;
      cyc = 0;
      inject = 1'b0;
      repeat (3) @(posedge clkin);
      @(negedge clkin);
      check_val("reset_outs", 32'({bitslip, aligned, data_valid, align_fail, slip_cnt}), 32'h0);
      check_val("reset_data", 32'(data_out), 32'h0);
      reset_n = 1'b1;
   endtask

   task automatic wait_aligned(input int budget, output int cnt);
      cnt = 0;
      while (!aligned && cnt < budget) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      // Test 2: stream rotated by 3, three slips needed
      pll_lock = 1'b1;
      base_rot = 4;
      never_match = 1'b0;
      apply_reset();
      wait_aligned(600, n);
      check_val("t2_aligned", 32'(aligned), 32'h1);
      check_val("t2_slips", 32'(slips_seen), 32'd3);
      check_val("t2_slip_cnt", 32'(slip_cnt), 32'd3);
      check_val("t2_gap_ge9", 32'(min_gap >= 9), 32'h1);
      check_val("t2_no_fail", 32'(align_fail), 32'h0);

      // Test 5: data path latency
      data_word = 28'h1234567;
      step();
      check_val("t5_data_a", 32'(data_out), 32'h1234567);
      check_val("t5_valid_a", 32'(data_valid), 32'h1);
      data_word = 28'hABCDEF0;
      step();
      check_val("t5_data_b", 32'(data_out), 32'hABCDEF0);

      // Test 4: three mismatches tolerated, four force re-check without slip
      slips_before = slips_seen;
      inject = 1'b1;
      repeat (3) step();
      check_val("t4_lock_3bad", 32'(aligned), 32'h1);
      inject = 1'b0;
      step();
      check_val("t4_lock_recov", 32'(aligned), 32'h1);
      inject = 1'b1;
      repeat (3) step();
      check_val("t4_lock_3bad_b", 32'(aligned), 32'h1);
      step();
      check_val("t4_unlock_4bad", 32'(aligned), 32'h0);
      check_val("t4_valid_lag", 32'(data_valid), 32'h1);
      inject = 1'b0;
      step();
      check_val("t4_valid_drop", 32'(data_valid), 32'h0);
      repeat (14) step();
      check_val("t4_check_15", 32'(aligned), 32'h0);
      step();
      check_val("t4_relock_16", 32'(aligned), 32'h1);
      check_val("t4_no_slip", 32'(slips_seen - slips_before), 32'd0);

      // Test 6: PLL lock loss and recovery
      pll_lock = 1'b0;
      repeat (2) step();
      check_val("t6_sync_lag", 32'(aligned), 32'h1);
      step();
      check_val("t6_unaligned", 32'(aligned), 32'h0);
      check_val("t6_bitslip", 32'(bitslip), 32'h0);
      step();
      check_val("t6_valid", 32'(data_valid), 32'h0);
      check_val("t6_slip_kept", 32'(slip_cnt), 32'd3);
      pll_lock = 1'b1;
      wait_aligned(300, n);
      check_val("t6_relock_lat", 32'(n >= 81 && n <= 83), 32'h1);
      check_val("t6_relock_noslip", 32'(slips_seen - slips_before), 32'd0);

      // Test 1: aligned from the start, lock after 2+64+16 cycles
      base_rot = 0;
      apply_reset();
      wait_aligned(300, n);
      check_val("t1_aligned", 32'(aligned), 32'h1);
      check_val("t1_latency", 32'(n >= 81 && n <= 83), 32'h1);
      check_val("t1_no_slip", 32'(slips_seen), 32'd0);

      // Test 3: pattern never seen, full rotation sets align_fail
      never_match = 1'b1;
      data_word = 28'h5A5A5A5;
      apply_reset();
      n = 0;
      while (slips_seen < 6 && n < 400) begin step(); n++; end
      step();
      step();
      check_val("t3_slip_cnt6", 32'(slip_cnt), 32'd6);
      check_val("t3_fail_early", 32'(align_fail), 32'h0);
      n = 0;
      while (slips_seen < 7 && n < 100) begin step(); n++; end
      step();
      step();
      check_val("t3_slip_wrap", 32'(slip_cnt), 32'd0);
      check_val("t3_fail_set", 32'(align_fail), 32'h1);
      check_val("t3_gap_ge9", 32'(min_gap >= 9), 32'h1);
      n = 0;
      while (slips_seen < 8 && n < 100) begin step(); n++; end
      check_val("t3_keeps_slip", 32'(slips_seen), 32'd8);
      repeat (3) step();
      check_val("t3_fail_sticky", 32'(align_fail), 32'h1);

      // Reset pulse in the middle of SLIP_WAIT
      #2;
      reset_n = 1'b0;
      #1;
      check_val("t6_rst_outs", 32'({bitslip, aligned, data_valid, align_fail, slip_cnt}), 32'h0);
      check_val("t6_rst_data", 32'(data_out), 32'h0);
      @(negedge clkin);
      reset_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
